// File: rtl/game_pkg.sv
// Shared game constants and state encoding for the flight game datapath.
// No ports; imported by flight_controller and btn_edge.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned PLAYER_H = 40;
  localparam int unsigned VEL_W    = 6;
  localparam int unsigned YS_W     = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-flop synchroniser followed by a rising-edge pulse.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   i_btn     - raw asynchronous button level
//   o_pulse_c - one-cycle pulse on a synchronised rising edge (combinational from flops)
module btn_edge
  import game_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse_c
);

  // [0],[1] synchronise; [2] holds the previous synchronised level
  logic [2:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], i_btn};
    end
  end

  assign o_pulse_c = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/flight_controller.sv
// Per-frame game-state engine: IDLE/PLAY/DEAD loop with gravity, flap,
// scroll, score and death blink. All outputs update only after frame_tick.
// Ports:
//   clk, rst     - pixel clock, synchronous active-high reset
//   frame_tick   - one-cycle pulse at the start of vblank
//   flap_btn     - raw button level
//   collide_pix  - player/obstacle overlap for the current pixel
//   y_pos        - player top y
//   x_offset     - obstacle scroll, 0..639
//   show_player  - player visibility
//   score        - passed obstacles, saturating at 255
//   state        - 0=IDLE, 1=PLAY, 2=DEAD
module flight_controller
  import game_pkg::*;
#(
  parameter int Y_START      = 240,
  parameter int Y_MAX        = 440,
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = -8,
  parameter int VEL_MAX      = 8,
  parameter int SCROLL       = 2,
  parameter int DEAD_FRAMES  = 60,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       flap_btn,
  input  logic       collide_pix,
  output logic [9:0] y_pos,
  output logic [9:0] x_offset,
  output logic       show_player,
  output logic [7:0] score,
  output logic [1:0] state
);

  localparam int unsigned DEAD_W  = $clog2(DEAD_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_PLAY = 2'(ST_PLAY);
  localparam logic [1:0] S_DEAD = 2'(ST_DEAD);

  localparam logic signed [VEL_W-1:0] FLAP_V    = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W:0]   VEL_MAX_X = (VEL_W+1)'(VEL_MAX);
  localparam logic signed [VEL_W:0]   GRAV_X    = (VEL_W+1)'(GRAVITY);
  localparam logic signed [YS_W-1:0]  Y_MAX_S   = YS_W'(Y_MAX);

  logic [1:0]               r_state,      w_state_n;
  logic [9:0]               r_y,          w_y_n;
  logic signed [VEL_W-1:0]  r_vel,        w_vel_n;
  logic [9:0]               r_x,          w_x_n;
  logic [7:0]               r_score,      w_score_n;
  logic                     r_show,       w_show_n;
  logic                     r_flap_pend,  w_flap_pend_n;
  logic                     r_hit,        w_hit_n;
  logic [DEAD_W-1:0]        r_dead_cnt,   w_dead_cnt_n;
  logic [BLINK_W-1:0]       r_blink_cnt,  w_blink_cnt_n;

  logic                     w_edge;
  logic                     w_flap;
  logic                     w_hit;
  logic signed [VEL_W:0]    w_vel_inc;
  logic signed [VEL_W-1:0]  w_vel_play;
  logic signed [YS_W-1:0]   w_y_play;
  logic [YS_W-1:0]          w_x_sum;
  logic [BLINK_W-1:0]       w_blink_inc;

  btn_edge u_btn (
    .clk       (clk),
    .rst       (rst),
    .i_btn     (flap_btn),
    .o_pulse_c (w_edge)
  );

  // Latched events plus same-cycle arrivals all count for the current frame
  assign w_flap = r_flap_pend | w_edge;
  assign w_hit  = r_hit | (collide_pix & (r_state == S_PLAY));

  // PLAY physics candidates
  assign w_vel_inc   = $signed({r_vel[VEL_W-1], r_vel}) + GRAV_X;
  assign w_vel_play  = w_flap ? FLAP_V
                     : ((w_vel_inc > VEL_MAX_X) ? VEL_W'(VEL_MAX) : w_vel_inc[VEL_W-1:0]);
  assign w_y_play    = $signed({1'b0, r_y})
                     + $signed({{(YS_W-VEL_W){w_vel_play[VEL_W-1]}}, w_vel_play});
  assign w_x_sum     = {1'b0, r_x} + YS_W'(SCROLL);
  assign w_blink_inc = r_blink_cnt + BLINK_W'(1);

  // Next-state and per-frame update
  always_comb begin
    w_state_n     = r_state;
    w_y_n         = r_y;
    w_vel_n       = r_vel;
    w_x_n         = r_x;
    w_score_n     = r_score;
    w_show_n      = r_show;
    w_dead_cnt_n  = r_dead_cnt;
    w_blink_cnt_n = r_blink_cnt;
    w_flap_pend_n = frame_tick ? 1'b0 : w_flap;
    w_hit_n       = frame_tick ? 1'b0 : w_hit;

    if (frame_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_flap) begin
            w_state_n = S_PLAY;
            w_vel_n   = FLAP_V;
            w_y_n     = 10'(Y_START + FLAP_VEL);
            w_x_n     = 10'd0;
            w_score_n = 8'd0;
          end
        end
        S_PLAY: begin
          if (w_hit) begin
            w_state_n     = S_DEAD;
            w_dead_cnt_n  = DEAD_W'(DEAD_FRAMES);
            w_blink_cnt_n = '0;
          end else if (w_y_play >= Y_MAX_S) begin
            w_state_n     = S_DEAD;
            w_y_n         = 10'(Y_MAX);
            w_vel_n       = w_vel_play;
            w_dead_cnt_n  = DEAD_W'(DEAD_FRAMES);
            w_blink_cnt_n = '0;
          end else begin
            // Ceiling clamp is not fatal; scroll continues
            if (w_y_play[YS_W-1]) begin
              w_y_n   = 10'd0;
              w_vel_n = '0;
            end else begin
              w_y_n   = w_y_play[9:0];
              w_vel_n = w_vel_play;
            end
            if (w_x_sum >= YS_W'(SCREEN_W)) begin
              w_x_n = 10'(w_x_sum - YS_W'(SCREEN_W));
              if (r_score != 8'hFF) begin
                w_score_n = r_score + 8'd1;
              end
            end else begin
              w_x_n = w_x_sum[9:0];
            end
          end
        end
        S_DEAD: begin
          if (w_blink_inc == BLINK_W'(BLINK_FRAMES)) begin
            w_show_n      = ~r_show;
            w_blink_cnt_n = '0;
          end else begin
            w_blink_cnt_n = w_blink_inc;
          end
          if (r_dead_cnt <= DEAD_W'(1)) begin
            w_state_n    = S_IDLE;
            w_dead_cnt_n = '0;
            w_y_n        = 10'(Y_START);
            w_vel_n      = '0;
            w_show_n     = 1'b1;
          end else begin
            w_dead_cnt_n = r_dead_cnt - DEAD_W'(1);
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_y         <= 10'(Y_START);
      r_vel       <= '0;
      r_x         <= 10'd0;
      r_score     <= 8'd0;
      r_show      <= 1'b1;
      r_flap_pend <= 1'b0;
      r_hit       <= 1'b0;
      r_dead_cnt  <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_y         <= w_y_n;
      r_vel       <= w_vel_n;
      r_x         <= w_x_n;
      r_score     <= w_score_n;
      r_show      <= w_show_n;
      r_flap_pend <= w_flap_pend_n;
      r_hit       <= w_hit_n;
      r_dead_cnt  <= w_dead_cnt_n;
      r_blink_cnt <= w_blink_cnt_n;
    end
  end

  assign y_pos       = r_y;
  assign x_offset    = r_x;
  assign show_player = r_show;
  assign score       = r_score;
  assign state       = r_state;

endmodule

// File: tb/tb_flight_controller.sv
// Directed bench for flight_controller. A second instance with a large
// scroll step shares all inputs so score wraps quickly (saturation, score=5).
module tb_flight_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       flap_btn = 1'b0;
  logic       collide_pix = 1'b0;
  logic [9:0] y_pos, x_offset, y2, x2;
  logic       show_player, show2;
  logic [7:0] score, score2;
  logic [1:0] state, state2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  flight_controller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap_btn(flap_btn),
    .collide_pix(collide_pix), .y_pos(y_pos), .x_offset(x_offset),
    .show_player(show_player), .score(score), .state(state)
  );

  flight_controller #(.SCROLL(320)) dut2 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap_btn(flap_btn),
    .collide_pix(collide_pix), .y_pos(y2), .x_offset(x2),
    .show_player(show2), .score(score2), .state(state2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    flap_btn = 1'b1;
    repeat (3) step();
    flap_btn = 1'b0;
    repeat (3) step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic frame(input bit do_flap);
    if (do_flap) press();
    step();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic start_game();
    do_reset();
    frame(1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (y_pos !== 10'd240) begin errors++; $display("FAIL reset_y: got %0d exp 240", y_pos); end
    checks++; if (x_offset !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d exp 0", x_offset); end
    checks++; if (show_player !== 1'b1) begin errors++; $display("FAIL reset_show: got %0d exp 1", show_player); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d exp 0", score); end
  endtask

  task automatic test_flap_physics();
    logic [9:0] exp_y [3];
    exp_y = '{10'd225, 10'd219, 10'd214};
    do_reset();
    press();
    checks++; if (state !== 2'd0 || y_pos !== 10'd240) begin errors++;
      $display("FAIL hold_no_tick: state %0d y %0d exp 0/240", state, y_pos); end
    step();
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d exp 1", state); end
    checks++; if (y_pos !== 10'd232) begin errors++; $display("FAIL start_y: got %0d exp 232", y_pos); end
    for (int i = 0; i < 3; i++) begin
      frame(1'b0);
      checks++; if (y_pos !== exp_y[i]) begin errors++;
        $display("FAIL gravity_y[%0d]: got %0d exp %0d", i, y_pos, exp_y[i]); end
    end
  endtask

  task automatic test_scroll_wrap();
    start_game();
    for (int i = 1; i <= 319; i++) frame(i % 8 == 0);
    checks++; if (x_offset !== 10'd638 || score !== 8'd0) begin errors++;
      $display("FAIL pre_wrap: x %0d score %0d exp 638/0", x_offset, score); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL alive_scroll: got %0d exp 1", state); end
    frame(1'b0);
    checks++; if (x_offset !== 10'd0 || score !== 8'd1) begin errors++;
      $display("FAIL wrap: x %0d score %0d exp 0/1", x_offset, score); end
  endtask

  task automatic test_score_saturation();
    start_game();
    for (int i = 1; i <= 508; i++) frame(i % 8 == 0);
    checks++; if (score2 !== 8'd254 || x2 !== 10'd0) begin errors++;
      $display("FAIL sat_254: score %0d x %0d exp 254/0", score2, x2); end
    frame(1'b0);
    frame(1'b1);
    checks++; if (score2 !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d exp 255", score2); end
    frame(1'b0);
    frame(1'b0);
    checks++; if (score2 !== 8'd255 || x2 !== 10'd0 || state2 !== 2'd1) begin errors++;
      $display("FAIL sat_hold: score %0d x %0d state %0d exp 255/0/1", score2, x2, state2); end
    checks++; if (score !== 8'd1 || x_offset !== 10'd384) begin errors++;
      $display("FAIL slow_scroll: score %0d x %0d exp 1/384", score, x_offset); end
  endtask

  task automatic test_floor_death();
    start_game();
    for (int i = 0; i < 16; i++) frame(1'b0);
    checks++; if (y_pos !== 10'd240) begin errors++; $display("FAIL fall_16: got %0d exp 240", y_pos); end
    for (int i = 0; i < 24; i++) frame(1'b0);
    checks++; if (state !== 2'd1 || y_pos !== 10'd432 || x_offset !== 10'd80) begin errors++;
      $display("FAIL fall_40: state %0d y %0d x %0d exp 1/432/80", state, y_pos, x_offset); end
    frame(1'b0);
    checks++; if (state !== 2'd2 || y_pos !== 10'd440 || x_offset !== 10'd80) begin errors++;
      $display("FAIL floor: state %0d y %0d x %0d exp 2/440/80", state, y_pos, x_offset); end
  endtask

  task automatic test_collision_blink();
    start_game();
    frame(1'b0);
    frame(1'b0);
    collide_pix = 1'b1;
    step();
    collide_pix = 1'b0;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL hit_wait_tick: got %0d exp 1", state); end
    tick();
    checks++; if (state !== 2'd2 || y_pos !== 10'd219 || x_offset !== 10'd4) begin errors++;
      $display("FAIL hit: state %0d y %0d x %0d exp 2/219/4", state, y_pos, x_offset); end
    for (int i = 1; i <= 60; i++) begin
      frame(1'b0);
      if (i == 7 || i == 8 || i == 16 || i == 59) begin
        checks++; if (show_player !== ((i == 7 || i == 16) ? 1'b1 : 1'b0) || state !== 2'd2) begin errors++;
          $display("FAIL blink[%0d]: show %0d state %0d", i, show_player, state); end
      end
    end
    checks++; if (state !== 2'd0 || y_pos !== 10'd240 || show_player !== 1'b1) begin errors++;
      $display("FAIL revive: state %0d y %0d show %0d exp 0/240/1", state, y_pos, show_player); end
    checks++; if (x_offset !== 10'd4 || score !== 8'd0) begin errors++;
      $display("FAIL revive_hold: x %0d score %0d exp 4/0", x_offset, score); end
  endtask

  task automatic test_same_cycle_priority();
    start_game();
    frame(1'b0);
    frame(1'b0);
    // Edge pulse appears after the second synchroniser flop; tick lands on it
    flap_btn = 1'b1;
    step();
    step();
    frame_tick = 1'b1;
    collide_pix = 1'b1;
    step();
    frame_tick = 1'b0;
    collide_pix = 1'b0;
    flap_btn = 1'b0;
    checks++; if (state !== 2'd2 || y_pos !== 10'd219 || x_offset !== 10'd4) begin errors++;
      $display("FAIL priority: state %0d y %0d x %0d exp 2/219/4", state, y_pos, x_offset); end
    for (int i = 0; i < 10; i++) frame(1'b1);
    checks++; if (state !== 2'd2 || y_pos !== 10'd219) begin errors++;
      $display("FAIL no_restart: state %0d y %0d exp 2/219", state, y_pos); end
  endtask

  task automatic test_reset_in_dead();
    start_game();
    for (int i = 1; i <= 10; i++) frame(i % 8 == 0);
    checks++; if (score2 !== 8'd5) begin errors++; $display("FAIL score5: got %0d exp 5", score2); end
    collide_pix = 1'b1;
    step();
    collide_pix = 1'b0;
    tick();
    frame(1'b0);
    checks++; if (state2 !== 2'd2) begin errors++; $display("FAIL dead_before_rst: got %0d exp 2", state2); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (state2 !== 2'd0 || y2 !== 10'd240 || x2 !== 10'd0 || score2 !== 8'd0 || show2 !== 1'b1) begin errors++;
      $display("FAIL rst_dead: state %0d y %0d x %0d score %0d show %0d", state2, y2, x2, score2, show2); end
    checks++; if (state !== 2'd0 || y_pos !== 10'd240 || show_player !== 1'b1) begin errors++;
      $display("FAIL rst_dead_main: state %0d y %0d show %0d", state, y_pos, show_player); end
  endtask

  initial begin
    test_reset();
    test_flap_physics();
    test_scroll_wrap();
    test_score_saturation();
    test_floor_death();
    test_collision_blink();
    test_same_cycle_priority();
    test_reset_in_dead();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flight_controller.md
Name: flight_controller

Overview:
- Per-frame game-state engine for the VGA game; sits directly upstream of the player and double_sin render stages.
- Produces `y_pos` and `show_player` for the player renderer, and `x_offset` for the double_sin obstacle renderer.
- Consumes the button input and a per-pixel collision strobe derived from the renderers' draw outputs.
- Runs the IDLE/PLAY/DEAD game loop: gravity, flap, scroll, score and death blink.

Parameters:
- Y_START, 240: player y on reset and on return to IDLE.
- Y_MAX, 440: lowest legal y (floor); reaching it kills the player.
- GRAVITY, 1: velocity increment per frame.
- FLAP_VEL, -8: signed velocity loaded on a flap.
- VEL_MAX, 8: maximum downward velocity.
- SCROLL, 2: `x_offset` advance per frame.
- DEAD_FRAMES, 60: frames spent in DEAD.
- BLINK_FRAMES, 8: `show_player` toggle period in DEAD.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: synchronous reset, active-high.
- frame_tick, in, 1: one-cycle pulse at the start of vblank (pix_x==0, pix_y==480).
- flap_btn, in, 1: raw asynchronous button level (from ui_in).
- collide_pix, in, 1: draw_player AND draw_double_sin for the current pixel.
- y_pos, out, 10: player top y.
- x_offset, out, 10: obstacle scroll, range 0..639.
- show_player, out, 1: player visibility.
- score, out, 8: passed obstacles, saturating.
- state, out, 2: 0=IDLE, 1=PLAY, 2=DEAD.

Behaviour:
- Reset values (one cycle after `rst` is sampled high, regardless of state): state=IDLE, y_pos=240, vel=0, x_offset=0, score=0, show_player=1. Flap and hit latches are cleared; dead counter=0.
- Button input: `flap_btn` passes through a 2-flop synchroniser, then a rising-edge detector.
  - A detected edge sets `flap_pend`.
  - Multiple edges within one frame count as one flap.
- Collision: `collide_pix`=1 while state=PLAY sets `hit_latch`; it is ignored in IDLE and DEAD.
- Outputs change only in the cycle after `frame_tick` (latency 1). Between ticks all outputs hold.
- Both latches are sampled at `frame_tick`, then cleared in the same update.
  - An edge or collision arriving in the same cycle as `frame_tick` counts for that frame.
- IDLE, on tick:
  - If `flap_pend`: go to PLAY; vel=FLAP_VEL; y_pos=Y_START+FLAP_VEL; x_offset=0; score=0.
  - Otherwise hold all values.
- PLAY, on tick, evaluated in this priority order:
  1. If `hit_latch`: go to DEAD; freeze y_pos and x_offset; dead counter=DEAD_FRAMES; blink counter=0.
  2. Velocity: vel_n = `flap_pend` ? FLAP_VEL : min(vel+GRAVITY, VEL_MAX).
  3. Position: y_n = y_pos + vel_n, computed in 11-bit signed arithmetic.
  4. If y_n<0: y_pos=0, vel=0 (ceiling clamp; not fatal).
  5. If y_n>=Y_MAX: y_pos=Y_MAX and go to DEAD, as in step 1.
  6. Otherwise y_pos=y_n.
  7. Scroll (steps 2–6 and this one skipped on death): x_offset = x_offset+SCROLL; if the result is >=640, subtract 640 and increment score, saturating at 255.
- DEAD, on tick:
  - Decrement dead counter.
  - Blink counter increments; `show_player` toggles when it reaches BLINK_FRAMES, and the counter then resets.
  - When the dead counter reaches 0: go to IDLE; y_pos=240; vel=0; show_player=1. x_offset and score hold until the next game start.
  - `flap_pend` is cleared each tick and cannot restart the game from DEAD.
- Velocity is a 6-bit signed register; the upper clamp applies only to downward motion.
- No combinational path exists from any input to any output; every output is a register.

Decomposition:
- Package `game_pkg` holds:
  - state enum (IDLE/PLAY/DEAD);
  - SCREEN_W=640, SCREEN_H=480, PLAYER_H=40;
  - the vel width constant.
- One sub-module, `btn_edge`: 2-flop synchroniser plus rising-edge pulse.
  - Same clk/rst convention as this block.
  - Reused later for other ui_in buttons.

Test Plan:
1. Reset in IDLE → state=0, y_pos=240, x_offset=0, show_player=1. flap_btn pulse then tick → state=1, y_pos=232; subsequent ticks without flap → y_pos=225, 219, 214.
2. In PLAY set x_offset=638 (run 319 ticks with periodic flaps) → next tick x_offset=0, score increments by 1; score held at 255 → stays 255 across a wrap.
3. No flaps from y=240 → vel climbs to 8 and clamps; y reaches 440 → state=2, y_pos=440, x_offset frozen.
4. One-cycle collide_pix mid-frame in PLAY → next tick state=2; show_player=0 after 8 ticks, 1 after 16; after 60 ticks state=0, y_pos=240, show_player=1.
5. flap_btn edge and collide_pix in the same cycle as frame_tick → death takes priority: state=2, y unchanged. Flap held during DEAD → no restart.
6. rst asserted for one cycle while in DEAD with score=5 → next cycle all reset values, score=0, show_player=1.
